// File: rtl/spi_arb_pkg.sv
// Shared constants for the SPI request arbiter: FSM state encoding,
// operation codes and a small state-classification helper.
package spi_arb_pkg;

    localparam int STATE_W = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic OP_WRITE = 1'b0;
    localparam logic OP_READ  = 1'b1;

    // The arbiter is busy whenever a transaction is in flight.
    function automatic logic is_busy_state(input logic [STATE_W-1:0] st);
        return (st != ST_IDLE);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: the search starts one past the last
// granted index and wraps, so the most recently served requester has the
// lowest priority.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    logic [IDX_W-1:0] cand_s;

    // Walk the requesters in rotated order and pick the first one pending.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand_s      = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand_s = IDX_W'((int'(last_grant) + off) % NUM_REQ);
            if (!grant_valid && req[cand_s]) begin
                grant_valid   = 1'b1;
                grant_idx     = cand_s;
                grant[cand_s] = 1'b1;
            end else begin
                grant_valid = grant_valid;
            end
        end
    end

endmodule

// File: rtl/spi_request_arbiter.sv
// Arbitrates several requesters onto a single SPI master. One transaction
// runs at a time: grant in IDLE, one-cycle start pulse, wait for the master
// (bounded by a timeout), then a one-cycle response to the granted requester.
module spi_request_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int OUT_WIDTH      = 16,
    parameter int IN_WIDTH       = 8,
    parameter int SS_WIDTH       = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*SS_WIDTH-1:0]   req_slave,
    input  logic [NUM_REQ-1:0]            req_op,
    input  logic [NUM_REQ*OUT_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [IN_WIDTH-1:0]           rsp_rdata,
    output logic                          rsp_timeout,
    output logic                          busy,
    output logic                          spi_start,
    output logic [SS_WIDTH-1:0]           spi_slave,
    output logic                          spi_operation,
    output logic [OUT_WIDTH-1:0]          spi_wdata,
    input  logic                          spi_end_of_transaction,
    input  logic [IN_WIDTH-1:0]           spi_rdata
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [STATE_W-1:0]   state_r;
    logic [STATE_W-1:0]   state_s;
    logic [IDX_W-1:0]     last_grant_r;
    logic [IDX_W-1:0]     gnt_idx_r;
    logic [NUM_REQ-1:0]   gnt_onehot_r;
    logic [CNT_W-1:0]     counter_r;
    logic                 terminal_s;

    logic [NUM_REQ-1:0]   arb_grant_s;
    logic [IDX_W-1:0]     arb_idx_s;
    logic                 arb_valid_s;

    logic [SS_WIDTH-1:0]  sel_slave_s;
    logic                 sel_op_s;
    logic [OUT_WIDTH-1:0] sel_wdata_s;

    logic [NUM_REQ-1:0]   rsp_valid_r;
    logic [IN_WIDTH-1:0]  rsp_rdata_r;
    logic                 rsp_timeout_r;
    logic                 busy_r;
    logic                 spi_start_r;
    logic [SS_WIDTH-1:0]  spi_slave_r;
    logic                 spi_operation_r;
    logic [OUT_WIDTH-1:0] spi_wdata_r;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req         (req_valid),
        .last_grant  (last_grant_r),
        .grant       (arb_grant_s),
        .grant_idx   (arb_idx_s),
        .grant_valid (arb_valid_s)
    );

    assign terminal_s = (counter_r == CNT_W'(TIMEOUT_CYCLES - 1));

    // Route the winning requester's transaction fields for latching.
    always_comb begin
        sel_slave_s = '0;
        sel_op_s    = OP_WRITE;
        sel_wdata_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx_s == IDX_W'(i)) begin
                sel_slave_s = req_slave[i*SS_WIDTH +: SS_WIDTH];
                sel_op_s    = req_op[i];
                sel_wdata_s = req_wdata[i*OUT_WIDTH +: OUT_WIDTH];
            end else begin
                sel_op_s = sel_op_s;
            end
        end
    end

    // Next-state decode; end_of_transaction is checked before the timeout so
    // it wins when both land in the same cycle, and is ignored outside WAIT.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (arb_valid_s) begin
                    state_s = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: state_s = ST_WAIT;
            ST_WAIT: begin
                if (spi_end_of_transaction || terminal_s) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Grant acceptance is a same-cycle handshake in IDLE, forced low in reset.
    always_comb begin
        if (rst_n && (state_r == ST_IDLE)) begin
            req_ready = arb_grant_s;
        end else begin
            req_ready = '0;
        end
    end

    // State, grant bookkeeping, timeout counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r         <= ST_IDLE;
            last_grant_r    <= IDX_W'(NUM_REQ - 1);
            gnt_idx_r       <= '0;
            gnt_onehot_r    <= '0;
            counter_r       <= '0;
            rsp_valid_r     <= '0;
            rsp_rdata_r     <= '0;
            rsp_timeout_r   <= 1'b0;
            busy_r          <= 1'b0;
            spi_start_r     <= 1'b0;
            spi_slave_r     <= '0;
            spi_operation_r <= 1'b0;
            spi_wdata_r     <= '0;
        end else begin
            state_r     <= state_s;
            busy_r      <= is_busy_state(state_s);
            spi_start_r <= (state_s == ST_START);
            case (state_r)
                ST_IDLE: begin
                    if (arb_valid_s) begin
                        gnt_idx_r       <= arb_idx_s;
                        gnt_onehot_r    <= arb_grant_s;
                        spi_slave_r     <= sel_slave_s;
                        spi_operation_r <= sel_op_s;
                        spi_wdata_r     <= sel_wdata_s;
                    end
                end
                ST_START: begin
                    counter_r <= '0;
                end
                ST_WAIT: begin
                    if (spi_end_of_transaction) begin
                        rsp_valid_r   <= gnt_onehot_r;
                        rsp_timeout_r <= 1'b0;
                        rsp_rdata_r   <= (spi_operation_r == OP_READ) ? spi_rdata : '0;
                    end else if (terminal_s) begin
                        rsp_valid_r   <= gnt_onehot_r;
                        rsp_timeout_r <= 1'b1;
                        rsp_rdata_r   <= '0;
                    end else begin
                        counter_r <= counter_r + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    last_grant_r  <= gnt_idx_r;
                    rsp_valid_r   <= '0;
                    rsp_timeout_r <= 1'b0;
                    rsp_rdata_r   <= '0;
                end
                default: begin
                    rsp_valid_r <= '0;
                end
            endcase
        end
    end

    assign rsp_valid     = rsp_valid_r;
    assign rsp_rdata     = rsp_rdata_r;
    assign rsp_timeout   = rsp_timeout_r;
    assign busy          = busy_r;
    assign spi_start     = spi_start_r;
    assign spi_slave     = spi_slave_r;
    assign spi_operation = spi_operation_r;
    assign spi_wdata     = spi_wdata_r;

endmodule

// File: tb/tb_spi_request_arbiter.sv
// Directed bench for spi_request_arbiter with a short timeout so the
// terminal-count paths are reached quickly.
module tb_spi_request_arbiter;

    localparam int NUM_REQ = 4;
    localparam int OUT_W   = 16;
    localparam int IN_W    = 8;
    localparam int SS_W    = 2;
    localparam int TMO     = 8;

    logic                      clk;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*SS_W-1:0]   req_slave;
    logic [NUM_REQ-1:0]        req_op;
    logic [NUM_REQ*OUT_W-1:0]  req_wdata;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [IN_W-1:0]           rsp_rdata;
    logic                      rsp_timeout;
    logic                      busy;
    logic                      spi_start;
    logic [SS_W-1:0]           spi_slave;
    logic                      spi_operation;
    logic [OUT_W-1:0]          spi_wdata;
    logic                      spi_end_of_transaction;
    logic [IN_W-1:0]           spi_rdata;

    int errors;
    int checks;

    spi_request_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .OUT_WIDTH      (OUT_W),
        .IN_WIDTH       (IN_W),
        .SS_WIDTH       (SS_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .req_valid              (req_valid),
        .req_ready              (req_ready),
        .req_slave              (req_slave),
        .req_op                 (req_op),
        .req_wdata              (req_wdata),
        .rsp_valid              (rsp_valid),
        .rsp_rdata              (rsp_rdata),
        .rsp_timeout            (rsp_timeout),
        .busy                   (busy),
        .spi_start              (spi_start),
        .spi_slave              (spi_slave),
        .spi_operation          (spi_operation),
        .spi_wdata              (spi_wdata),
        .spi_end_of_transaction (spi_end_of_transaction),
        .spi_rdata              (spi_rdata)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hard bound on run time.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        req_valid = 4'b1111;
        req_op = 4'b0000;
        req_slave = {2'b10, 2'b11, 2'b01, 2'b00};
        req_wdata = {16'h4444, 16'h3333, 16'h1A6A, 16'h1111};
        spi_end_of_transaction = 1'b0;
        spi_rdata = 8'h00;
        step();
        step();
        #1;
        check_val("rst_ready", 32'(req_ready), 32'h0);
        check_val("rst_busy", 32'(busy), 32'h0);
        check_val("rst_start", 32'(spi_start), 32'h0);
        check_val("rst_rsp", 32'(rsp_valid), 32'h0);

        // Single write from requester 1.
        req_valid = 4'b0000;
        rst_n = 1'b1;
        step();
        req_valid = 4'b0010;
        #1;
        check_val("w_ready", 32'(req_ready), 32'h2);
        step();
        req_valid = 4'b0000;
        check_val("w_start", 32'(spi_start), 32'h1);
        check_val("w_wdata", 32'(spi_wdata), 32'h1A6A);
        check_val("w_slave", 32'(spi_slave), 32'h1);
        check_val("w_op", 32'(spi_operation), 32'h0);
        check_val("w_busy", 32'(busy), 32'h1);
        step();
        check_val("w_start_off", 32'(spi_start), 32'h0);
        spi_end_of_transaction = 1'b1;
        spi_rdata = 8'h77;
        step();
        spi_end_of_transaction = 1'b0;
        check_val("w_rsp", 32'(rsp_valid), 32'h2);
        check_val("w_rdata", 32'(rsp_rdata), 32'h0);
        check_val("w_tmo", 32'(rsp_timeout), 32'h0);
        check_val("w_wdata_hold", 32'(spi_wdata), 32'h1A6A);
        step();
        check_val("w_rsp_off", 32'(rsp_valid), 32'h0);
        check_val("w_idle", 32'(busy), 32'h0);

        // Read from requester 2; eot outside WAIT is ignored.
        req_op = 4'b0100;
        req_valid = 4'b0100;
        spi_end_of_transaction = 1'b1;
        spi_rdata = 8'h95;
        #1;
        check_val("r_ready", 32'(req_ready), 32'h4);
        step();
        req_valid = 4'b0000;
        check_val("r_op", 32'(spi_operation), 32'h1);
        check_val("r_slave", 32'(spi_slave), 32'h3);
        check_val("r_wdata", 32'(spi_wdata), 32'h3333);
        spi_end_of_transaction = 1'b0;
        step();
        check_val("r_ign_eot", 32'(rsp_valid), 32'h0);
        step();
        check_val("r_wait", 32'(busy), 32'h1);
        spi_end_of_transaction = 1'b1;
        step();
        spi_end_of_transaction = 1'b0;
        check_val("r_rsp", 32'(rsp_valid), 32'h4);
        check_val("r_rdata", 32'(rsp_rdata), 32'h95);
        check_val("r_tmo", 32'(rsp_timeout), 32'h0);
        check_val("r_slave_hold", 32'(spi_slave), 32'h3);
        step();
        check_val("r_rsp_off", 32'(rsp_valid), 32'h0);

        // Timeout on requester 3 (last grant was 2).
        req_op = 4'b1000;
        req_valid = 4'b1000;
        spi_rdata = 8'hAA;
        #1;
        check_val("t_ready", 32'(req_ready), 32'h8);
        step();
        req_valid = 4'b0000;
        step();
        for (int i = 1; i < TMO; i++) step();
        check_val("t_early", 32'(rsp_valid), 32'h0);
        step();
        check_val("t_rsp", 32'(rsp_valid), 32'h8);
        check_val("t_tmo", 32'(rsp_timeout), 32'h1);
        check_val("t_rdata", 32'(rsp_rdata), 32'h0);
        step();
        check_val("t_rsp_off", 32'(rsp_valid), 32'h0);

        // End of transaction exactly on the terminal cycle wins.
        req_op = 4'b0001;
        req_valid = 4'b0001;
        #1;
        check_val("te_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = 4'b0000;
        step();
        for (int i = 1; i < TMO; i++) step();
        spi_end_of_transaction = 1'b1;
        spi_rdata = 8'h5A;
        step();
        spi_end_of_transaction = 1'b0;
        check_val("te_rsp", 32'(rsp_valid), 32'h1);
        check_val("te_tmo", 32'(rsp_timeout), 32'h0);
        check_val("te_rdata", 32'(rsp_rdata), 32'h5A);
        step();

        // Reset in WAIT aborts the transaction with no response.
        req_op = 4'b0000;
        req_valid = 4'b0010;
        #1;
        check_val("x_ready", 32'(req_ready), 32'h2);
        step();
        req_valid = 4'b0000;
        step();
        rst_n = 1'b0;
        step();
        check_val("x_busy", 32'(busy), 32'h0);
        check_val("x_rsp", 32'(rsp_valid), 32'h0);
        check_val("x_wdata", 32'(spi_wdata), 32'h0);
        check_val("x_slave", 32'(spi_slave), 32'h0);
        check_val("x_start", 32'(spi_start), 32'h0);
        rst_n = 1'b1;
        req_valid = 4'b0011;
        #1;
        check_val("x_first", 32'(req_ready), 32'h1);

        // All requesters held valid: back-to-back grants 0,1,2,3,0.
        req_valid = 4'b1111;
        spi_rdata = 8'h00;
        for (int k = 0; k < 5; k++) begin
            logic [3:0] exp_oh;
            exp_oh = 4'b0001 << (k % 4);
            #1;
            check_val("rr_ready", 32'(req_ready), 32'(exp_oh));
            step();
            step();
            spi_end_of_transaction = 1'b1;
            step();
            spi_end_of_transaction = 1'b0;
            check_val("rr_rsp", 32'(rsp_valid), 32'(exp_oh));
            step();
        end

        // Requester 1 drops its request before the edge and is skipped.
        req_valid = 4'b0010;
        #1;
        check_val("d_ready1", 32'(req_ready), 32'h2);
        req_valid = 4'b0100;
        #1;
        check_val("d_ready2", 32'(req_ready), 32'h4);
        step();
        req_valid = 4'b0000;
        check_val("d_slave", 32'(spi_slave), 32'h3);
        step();
        spi_end_of_transaction = 1'b1;
        step();
        spi_end_of_transaction = 1'b0;
        check_val("d_rsp", 32'(rsp_valid), 32'h4);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
